// File: rtl/alu_input_loader.sv
// Board front end for the ALU: conditions three push buttons and sequences
// loading of operand A, operand B and the opcode from the slide switches.
module alu_input_loader #(
    parameter int SIZE            = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] i_sw,
    input  logic            i_btnA,
    input  logic            i_btnB,
    input  logic            i_btnOP,
    input  logic [SIZE:0]   i_res_alu,
    input  logic            i_carry,
    output logic [SIZE-1:0] o_a,
    output logic [SIZE-1:0] o_b,
    output logic [5:0]      o_opCode,
    output logic [SIZE:0]   o_led,
    output logic            o_carry_led,
    output logic            o_valid,
    output logic [1:0]      o_state
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    state_t        state;
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [2:0]    stable_d;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];

    // Bit 0 = A, bit 1 = B, bit 2 = OP throughout the conditioning path.
    assign raw = {i_btnOP, i_btnB, i_btnA};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_A;
            o_a         <= '0;
            o_b         <= '0;
            o_opCode    <= '0;
            o_led       <= '0;
            o_carry_led <= 1'b0;
            o_valid     <= 1'b0;
        end else begin
            case (state)
                S_A: begin
                    if (press[0]) begin
                        o_a   <= i_sw;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (press[1]) begin
                        o_b   <= i_sw;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (press[2]) begin
                        o_opCode <= i_sw[5:0];
                        o_valid  <= 1'b1;
                        state    <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    // The ALU is combinational, so its result settles one cycle after the opcode lands.
                    o_led       <= i_res_alu;
                    o_carry_led <= i_carry;
                    if (press[0]) begin
                        o_a     <= i_sw;
                        o_valid <= 1'b0;
                        state   <= S_B;
                    end
                end
                default: state <= S_A;
            endcase
        end
    end

    assign o_state = state;

endmodule
